// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the 2:1 mux arbiter.
// Burst-hold behaviour is compiled in with MUX_ARB_BURST_EN.
package mux_arb_pkg;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  localparam int W_DEF         = 4;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } ptr_t;

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic logic ptr_to_gnt(input ptr_t p);
    return (p == LAST_B) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant logic, purely combinational.
// With MUX_ARB_BURST_EN the last grantee may keep the grant for a bounded burst.
module arb_rr2
  import mux_arb_pkg::*;
#(
`ifdef MUX_ARB_BURST_EN
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = cnt_width(MAX_BURST_DEF)
`else
  parameter int UNUSED_P  = 0
`endif
) (
  input  logic             a_valid,
  input  logic             b_valid,
  input  ptr_t             ptr,
`ifdef MUX_ARB_BURST_EN
  input  logic [CNT_W-1:0] burst_cnt,
`endif
  output logic             grant,
  output logic             grant_vld
);

  logic last_gnt;
  logic other_gnt;

  assign last_gnt  = ptr_to_gnt(ptr);
  assign other_gnt = ~last_gnt;

`ifdef MUX_ARB_BURST_EN
  logic hold_burst;

  // A zero count means the previous grantee has no burst in progress.
  assign hold_burst = (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST));
`endif

  always_comb begin
    grant     = GNT_A;
    grant_vld = a_valid | b_valid;
    if (a_valid && b_valid) begin
`ifdef MUX_ARB_BURST_EN
      grant = hold_burst ? last_gnt : other_gnt;
`else
      grant = other_gnt;
`endif
    end else if (b_valid) begin
      grant = GNT_B;
    end else begin
      grant = GNT_A;
    end
  end

endmodule

// File: rtl/mux_arb_2to1.sv
// Arbitrated 2:1 mux with a registered y stream and select output.
// Optional burst hold under contention via MUX_ARB_BURST_EN.
module mux_arb_2to1
  import mux_arb_pkg::*;
#(
  parameter int W = W_DEF
`ifdef MUX_ARB_BURST_EN
  ,
  parameter int MAX_BURST = MAX_BURST_DEF
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  input  logic         y_ready,
  output logic         s
);

  logic load;
  logic grant;
  logic grant_vld;
  logic xfer;
  ptr_t ptr_q;
  ptr_t ptr_d;
  ptr_t ptr_arb;

`ifdef MUX_ARB_BURST_EN
  localparam int CNT_W = cnt_width(MAX_BURST);

  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_d;
`endif

  assign load = ~y_valid | y_ready;
  assign xfer = load & grant_vld;

  arb_rr2
`ifdef MUX_ARB_BURST_EN
  #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  )
`endif
  u_arb (
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .ptr       (ptr_arb),
`ifdef MUX_ARB_BURST_EN
    .burst_cnt (burst_cnt_q),
`endif
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // Readies are gated by rst_n so they drop immediately on reset assertion.
  assign a_ready = rst_n & xfer & (grant == GNT_A);
  assign b_ready = rst_n & xfer & (grant == GNT_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      s       <= GNT_A;
    end else if (load) begin
      if (grant_vld) begin
        y_valid <= 1'b1;
        y_data  <= (grant == GNT_B) ? b_data : a_data;
        s       <= grant;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

  // Pointer FSM
  //   state  | meaning
  //   LAST_A | a received the most recent accepted beat
  //   LAST_B | b received the most recent accepted beat (reset: a wins first contention)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= LAST_B;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (grant == GNT_B) ? LAST_B : LAST_A;
    end
  end

  always_comb begin
    ptr_arb = ptr_q;
  end

`ifdef MUX_ARB_BURST_EN
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (load) begin
      if (!grant_vld) begin
        burst_cnt_d = '0;
      end else if ((grant == ptr_to_gnt(ptr_q)) && (burst_cnt_q != '0)) begin
        if (burst_cnt_q != CNT_W'(MAX_BURST)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end else begin
        burst_cnt_d = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

endmodule
